// File: rtl/bt_header_serializer_ble.sv
// BLE/BT packet-header serializer: captures the 10-bit header and UAP on start, emits LSB-first with bit pacing.
// Optional HDR_ABORT_EN adds an abort input that cancels an in-flight header.
module bt_header_serializer_ble #(
  parameter int unsigned HDR_BITS    = 10,
  parameter int unsigned CYC_PER_BIT = 1,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       lt_addr,
  input  logic [3:0]       pkt_type,
  input  logic             flow,
  input  logic             arqn,
  input  logic             seqn,
  input  logic [7:0]       uap_in,
`ifdef HDR_ABORT_EN
  input  logic             abort,
`endif
  output logic             valid_out,
  output logic             data_out,
  output logic [7:0]       uap_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned PACE_W = (CYC_PER_BIT > 1) ? $clog2(CYC_PER_BIT) : 1;
  localparam int unsigned FLD_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [HDR_BITS-1:0] sr_q, sr_d;
  logic [PACE_W-1:0]   pace_q, pace_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]          uap_q, uap_d;
  logic                valid_q, valid_d;
  logic                data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [FLD_W-1:0]    hdr_c;
  logic                abort_c;
  logic                slot_start_c;
  logic                slot_last_c;

`ifdef HDR_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  assign hdr_c        = {seqn, arqn, flow, pkt_type, lt_addr};
  assign slot_start_c = (pace_q == PACE_W'(0));
  assign slot_last_c  = (pace_q == PACE_W'(CYC_PER_BIT - 1));

  // Next-state, datapath and registered-output values
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    pace_d    = pace_q;
    bit_cnt_d = bit_cnt_q;
    uap_d     = uap_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          sr_d      = HDR_BITS'(hdr_c);
          uap_d     = uap_in;
          pace_d    = PACE_W'(0);
          bit_cnt_d = CNT_W'(0);
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy_d = 1'b1;
        if (abort_c) begin
          busy_d    = 1'b0;
          bit_cnt_d = CNT_W'(0);
          pace_d    = PACE_W'(0);
          state_d   = ST_IDLE;
        end else if (slot_start_c && (bit_cnt_q == CNT_W'(HDR_BITS))) begin
          // The slot after the last bit slot closes the header
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          if (slot_start_c) begin
            valid_d   = 1'b1;
            data_d    = sr_q[0];
            sr_d      = sr_q >> 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          pace_d = slot_last_c ? PACE_W'(0) : pace_q + PACE_W'(1);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      pace_q    <= '0;
      bit_cnt_q <= '0;
      uap_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      pace_q    <= pace_d;
      bit_cnt_q <= bit_cnt_d;
      uap_q     <= uap_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign uap_out   = uap_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_bt_header_serializer_ble.sv
// Self-checking bench for bt_header_serializer_ble: vector table, scoreboard of LSB-first header bits,
// pacing at CYC_PER_BIT=3, ignored starts, async reset, optional abort, back-to-back random headers.
module tb_bt_header_serializer_ble;

  localparam int unsigned CNT_W = 4;

  typedef struct {
    logic [2:0] lt;
    logic [3:0] ty;
    logic       fl;
    logic       ar;
    logic       sq;
    logic [7:0] uap;
    logic [9:0] exp_hdr;
  } vec_t;

  logic clk = 1'b0;
  logic reset, start, start3, abort;
  logic [2:0] lt_addr;
  logic [3:0] pkt_type;
  logic flow, arqn, seqn;
  logic [7:0] uap_in;

  logic valid_out, data_out, busy, done;
  logic [7:0] uap_out;
  logic [CNT_W-1:0] bit_count;
  logic valid3, data3, busy3, done3;
  logic [7:0] uap3;
  logic [CNT_W-1:0] bit_count3;

  always #5 clk = ~clk;

  bt_header_serializer_ble #(.HDR_BITS(10), .CYC_PER_BIT(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .lt_addr(lt_addr), .pkt_type(pkt_type),
    .flow(flow), .arqn(arqn), .seqn(seqn), .uap_in(uap_in),
`ifdef HDR_ABORT_EN
    .abort(abort),
`endif
    .valid_out(valid_out), .data_out(data_out), .uap_out(uap_out), .busy(busy),
    .done(done), .bit_count(bit_count)
  );

  bt_header_serializer_ble #(.HDR_BITS(10), .CYC_PER_BIT(3), .CNT_W(CNT_W)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .lt_addr(lt_addr), .pkt_type(pkt_type),
    .flow(flow), .arqn(arqn), .seqn(seqn), .uap_in(uap_in),
`ifdef HDR_ABORT_EN
    .abort(1'b0),
`endif
    .valid_out(valid3), .data_out(data3), .uap_out(uap3), .busy(busy3),
    .done(done3), .bit_count(bit_count3)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_seen = 0;
  int total_valid = 0;
  int hdr_bits = 0;
  logic exp_q[$];
  logic [7:0] exp_uap = 8'h00;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitor for the CYC_PER_BIT=1 instance
  always @(negedge clk) begin
    logic eb;
    if (reset) begin
      if (valid_out) begin
        total_valid++;
        hdr_bits++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL valid_unexpected: valid_out=1 with empty scoreboard (cycle %0d)", cyc);
        end else begin
          eb = exp_q.pop_front();
          check("data_out", 32'(data_out), 32'(eb));
        end
        check("bit_count", 32'(bit_count), 32'(hdr_bits));
        check("uap_out", 32'(uap_out), 32'(exp_uap));
      end
      if (done) begin
        done_seen++;
        check("done_latency", 32'(cyc - acc_cyc), 32'd11);
        check("done_sb_empty", 32'(exp_q.size()), 32'd0);
        check("done_bit_count", 32'(bit_count), 32'd10);
        check("done_busy", 32'(busy), 32'd1);
      end
    end
  end

  task automatic arm(input vec_t v);
    acc_cyc  = cyc;
    exp_uap  = v.uap;
    hdr_bits = 0;
    for (int b = 0; b < 10; b++) exp_q.push_back(v.exp_hdr[b]);
  endtask

  task automatic set_fields(input vec_t v);
    lt_addr = v.lt; pkt_type = v.ty; flow = v.fl; arqn = v.ar; seqn = v.sq; uap_in = v.uap;
  endtask

  task automatic drive_start(input vec_t v);
    @(posedge clk); #1;
    set_fields(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    arm(v);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_bit_count", 32'(bit_count), 32'd0);
    check("accept_uap", 32'(uap_out), 32'(v.uap));
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_seen >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout: done count %0d required %0d", done_seen, target);
    end
  endtask

  initial begin
    int dn;
    int a3;
    int k;
    int tv0;
    int d0;
    logic exp_v;
    vec_t rv;

    vecs[0] = '{lt: 3'b101, ty: 4'b0011, fl: 1'b1, ar: 1'b0, sq: 1'b1, uap: 8'h47, exp_hdr: 10'h29D};
    vecs[1] = '{lt: 3'b000, ty: 4'b0000, fl: 1'b0, ar: 1'b0, sq: 1'b0, uap: 8'h00, exp_hdr: 10'h000};
    vecs[2] = '{lt: 3'b111, ty: 4'b1111, fl: 1'b1, ar: 1'b1, sq: 1'b1, uap: 8'hFF, exp_hdr: 10'h3FF};
    vecs[3] = '{lt: 3'b010, ty: 4'b1010, fl: 1'b0, ar: 1'b1, sq: 1'b0, uap: 8'h5A, exp_hdr: 10'h152};
    vecs[4] = '{lt: 3'b001, ty: 4'b0100, fl: 1'b0, ar: 1'b0, sq: 1'b1, uap: 8'hC3, exp_hdr: 10'h221};

    reset = 1'b0; start = 1'b0; start3 = 1'b0; abort = 1'b0;
    set_fields(vecs[1]);
    dn = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_uap", 32'(uap_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bit_count", 32'(bit_count), 32'd0);
    reset = 1'b1;

    // Table-driven headers
    for (int i = 0; i < 5; i++) begin
      drive_start(vecs[i]);
      dn++;
      wait_done(dn);
    end
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_bit_count_held", 32'(bit_count), 32'd10);
    check("idle_uap_held", 32'(uap_out), 32'hC3);

    // Pacing at CYC_PER_BIT=3
    @(posedge clk); #1;
    set_fields(vecs[2]);
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    a3 = cyc;
    for (int j = 0; j < 35; j++) begin
      @(negedge clk);
      k = cyc - a3;
      exp_v = (k >= 1 && k <= 28 && ((k - 1) % 3) == 0);
      check("p3_valid", 32'(valid3), 32'(exp_v));
      if (exp_v) check("p3_data", 32'(data3), 32'd1);
      check("p3_done", 32'(done3), 32'(k == 31));
      if (k == 31) begin
        check("p3_bit_count", 32'(bit_count3), 32'd10);
        check("p3_uap", 32'(uap3), 32'hFF);
      end
    end

    // Ignored starts and field changes mid-header, then start at done+1
    drive_start(vecs[0]);
    repeat (2) @(posedge clk);
    #1 set_fields(vecs[2]);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 begin start = 1'b1; set_fields(vecs[4]); end
    check("t4_done_cycle", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("t4_idle_after_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    arm(vecs[4]);
    check("t4_restart_busy", 32'(busy), 32'd1);
    dn += 2;
    wait_done(dn);

    // Async reset mid-header
    drive_start(vecs[3]);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid_out), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_bit_count", 32'(bit_count), 32'd0);
    check("mid_rst_uap", 32'(uap_out), 32'd0);
    exp_q.delete();
    d0 = done_seen;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (15) @(posedge clk);
    #1 check("mid_rst_no_done", 32'(done_seen), 32'(d0));
    drive_start(vecs[0]);
    dn = done_seen + 1;
    wait_done(dn);

`ifdef HDR_ABORT_EN
    drive_start(vecs[2]);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_valid", 32'(valid_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bit_count", 32'(bit_count), 32'd0);
    check("abort_sb_left", 32'(exp_q.size()), 32'd6);
    exp_q.delete();
    d0 = done_seen;
    repeat (15) @(posedge clk);
    #1 check("abort_no_done", 32'(done_seen), 32'(d0));
    drive_start(vecs[3]);
    dn = done_seen + 1;
    wait_done(dn);
`endif

    // Back-to-back random headers, each started at done+1
    tv0 = total_valid;
    for (int h = 0; h < 100; h++) begin
      rv.lt  = 3'($urandom_range(0, 7));
      rv.ty  = 4'($urandom_range(0, 15));
      rv.fl  = 1'($urandom_range(0, 1));
      rv.ar  = 1'($urandom_range(0, 1));
      rv.sq  = 1'($urandom_range(0, 1));
      rv.uap = 8'($urandom_range(0, 255));
      rv.exp_hdr = {rv.sq, rv.ar, rv.fl, rv.ty, rv.lt};
      drive_start(rv);
      dn = done_seen + 1;
      wait_done(dn);
    end
    check("b2b_total_bits", 32'(total_valid - tv0), 32'd1000);
    check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
